uart_rx_oversampled: RTL
========================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 Parameter OVERSAMPLE, fixed at 16, sample ticks per bit.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 RXD  input  1  asynchronous serial line, idle high.
REQ-007 rd_en  input  1  pops head FIFO entry when Valid_rx=1.
REQ-008 RX_Data  output  8  data byte of FIFO head entry (first-word-fall-through).
REQ-009 Valid_rx  output  1  FIFO not empty.
REQ-010 Parity_error  output  1  parity-error flag of head entry.
REQ-011 Stop_error  output  1  stop-error flag of head entry.
REQ-012 overrun  output  1  one-cycle pulse when a completed frame is dropped (FIFO full).
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 Frame format: 1 start (0), 8 data LSB first, 1 even-parity bit, 1 stop (1).
REQ-015 RXD passes a 2-flop synchronizer before use; both flops reset to 1.
REQ-016 Sample tick: free-running divider pulses once every DIV = CLK_FREQ/(BAUD_RATE*16) clocks (integer truncation, DIV>=1), runs in every state.
REQ-017 Per-bit tick counter 0..15; reset to 0 on start detection; wraps 15->0, advancing the bit.
REQ-018 Bit value = majority of synchronized samples at ticks 7, 8, 9; decision taken at tick 9.
REQ-019 States: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: synchronized 1->0 transition -> START; a line held low never triggers (edge required).
REQ-021 START: decision 1 -> IDLE (glitch rejected, nothing stored); 0 -> DATA at tick 15 wrap.
REQ-022 DATA: shift in decided bit; after 8th bit's tick-15 wrap -> PARITY.
REQ-023 PARITY: error = XOR(8 data bits, parity bit) != 0; -> STOP at tick-15 wrap.
REQ-024 STOP: at decision (tick 9) commit {Stop_error = (bit==0), Parity_error, data} and go to IDLE same cycle.
REQ-025 FIFO: 4 entries x 10 bits, wrap-around 2-bit pointers plus count; head presented combinationally on RX_Data/Parity_error/Stop_error.
REQ-026 rd_en with Valid_rx=0 ignored; commit with FIFO full drops frame, pulses overrun, FIFO unchanged.
REQ-027 Simultaneous commit and pop when full: pop first, commit accepted, no overrun; count stays 4.
REQ-028 Simultaneous commit and pop when count 1..3: count unchanged, data ordering preserved.
REQ-029 Head outputs are don't-care while Valid_rx=0 but hold last value (no X).
REQ-030 Latency: Valid_rx rises one clk after the stop-bit tick-9 decision.

Reset
REQ-031 On reset: FSM IDLE, divider/tick/bit counters 0, shift register 0, FIFO empty.
REQ-032 Reset outputs: RX_Data=0, Valid_rx=0, Parity_error=0, Stop_error=0, overrun=0, busy=0.
REQ-033 Reset mid-frame discards partial frame; after release, a frame needs a fresh falling edge.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> DIV=1, 16 clk/bit)
REQ-034 Send 0xA5, parity 0, stop 1 -> Valid_rx=1, RX_Data=0xA5, both error flags 0; rd_en -> Valid_rx=0.
REQ-035 Send 0x01 with parity bit 0 -> RX_Data=0x01, Parity_error=1, Stop_error=0.
REQ-036 Send 0x3C, stop bit 0, line held low 40 bits -> one entry, Stop_error=1, no second frame until line returns high then falls.
REQ-037 Low pulse of 4 clk on idle line -> busy high then low, Valid_rx stays 0.
REQ-038 Send 5 frames 0x10..0x14 with no reads -> 4 entries 0x10..0x13, overrun pulses once on 5th; pops return 0x10..0x13 in order.
REQ-039 Assert reset during DATA bit 4 of 0xFF -> all outputs 0 immediately; next clean frame 0x55 received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// Serial line and FIFO-read handshake of the 16x oversampling UART receiver.
// master = line driver / FIFO reader, slave = the receiver itself.
interface uart_rx_oversampled_if;
   logic       RXD;
   logic       rd_en;
   logic [7:0] RX_Data;
   logic       Valid_rx;
   logic       Parity_error;
   logic       Stop_error;
   logic       overrun;
   logic       busy;

   modport master (
      output RXD, rd_en,
      input  RX_Data, Valid_rx, Parity_error, Stop_error, overrun, busy
   );

   modport slave (
      input  RXD, rd_en,
      output RX_Data, Valid_rx, Parity_error, Stop_error, overrun, busy
   );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x oversampling UART receiver (8E1) with majority-vote bit decisions and a
// 4-entry first-word-fall-through FIFO holding {stop_err, parity_err, data}.
module uart_rx_oversampled #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_rx_oversampled_if.slave  bus
);
   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // line synchronizer plus one extra stage for falling-edge detection
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.RXD;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   logic [DIV_W-1:0] div_q;
   logic             tick;

   assign tick = (div_q == DIV_W'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_q <= '0;
      else       div_q <= tick ? '0 : div_q + 1'b1;
   end

   state_t      state_q;
   logic [3:0]  tick_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        par_err_q;
   logic        smp7_q, smp8_q;
   logic        busy_q;
   logic        maj, at_dec, at_wrap, frame_done;
   logic [9:0]  frame_word;

   assign maj     = (smp7_q & smp8_q) | (smp7_q & rx_sync_q) | (smp8_q & rx_sync_q);
   assign at_dec  = tick && (tick_q == 4'd9);
   assign at_wrap = tick && (tick_q == 4'(OVERSAMPLE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         smp7_q    <= 1'b1;
         smp8_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         if (state_q != S_IDLE && tick) begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == 4'd7) smp7_q <= rx_sync_q;
            if (tick_q == 4'd8) smp8_q <= rx_sync_q;
         end
         case (state_q)
            S_IDLE: begin
               tick_q <= '0;
               // an edge is required, so a line stuck low never starts a frame
               if (rx_prev_q && !rx_sync_q) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (at_dec && maj) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (at_wrap) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            end
            S_DATA: begin
               if (at_dec) shift_q <= {maj, shift_q[7:1]};
               if (at_wrap) begin
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (at_dec)  par_err_q <= (^shift_q) ^ maj;
               if (at_wrap) state_q   <= S_STOP;
            end
            S_STOP: begin
               if (at_dec) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign frame_done = (state_q == S_STOP) && at_dec;
   assign frame_word = {~maj, par_err_q, shift_q};

   logic [3:0][9:0] mem_q;
   logic [9:0]      last_q, head;
   logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            ovr_q, ovr_d;
   logic            pop, push;

   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   always_comb begin
      pop      = bus.rd_en && (cnt_q != 3'd0);
      push     = frame_done && ((cnt_q != 3'd4) || pop);
      cnt_d    = cnt_q + {2'b0, push} - {2'b0, pop};
      wr_ptr_d = wr_ptr_q + {1'b0, push};
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      ovr_d    = frame_done && !push;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '0;
         last_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= frame_word;
         if (pop)  last_q          <= mem_q[rd_ptr_q];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovr_q    <= ovr_d;
      end
   end

   // when empty, keep showing the most recently popped entry
   assign head = (cnt_q != 3'd0) ? mem_q[rd_ptr_q] : last_q;

   assign bus.RX_Data      = head[7:0];
   assign bus.Parity_error = head[8];
   assign bus.Stop_error   = head[9];
   assign bus.Valid_rx     = (cnt_q != 3'd0);
   assign bus.overrun      = ovr_q;
   assign bus.busy         = busy_q;
endmodule
